learning_engine: RTL and testbench

Parametrised next-generation learning-mode core for the piano. Walks a song stored in note memory, plays each note on the buzzer, waits for the player to press the matching key, and scores the attempt. Wrong or late presses trigger replays with a bounded retry count. Sits between the song memory and the existing LED, buzzer and score-display drivers.

---
 rtl/learn_pkg.sv | 25 ++
 rtl/learn_note_timer.sv | 28 ++
 rtl/learning_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_learning_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/learn_pkg.sv
// Shared types and constants for the piano learning-mode core.
// The streak/bonus feature is compiled in only when LEARN_STREAK_EN is defined.
package learn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_PROMPT  = 3'd3,
        ST_LISTEN  = 3'd4,
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6
    } learn_state_e;

    localparam int unsigned BONUS_INTERVAL = 4;

    function automatic logic [31:0] end_code(input int unsigned key_w);
        return (32'd1 << key_w) - 32'd1;
    endfunction

    function automatic logic [31:0] rest_code(input int unsigned key_w);
        return 32'd0 & end_code(key_w);
    endfunction

endpackage

// File: rtl/learn_note_timer.sv
// Loadable down-counter used to time both the note prompt and the answer window.
// expire_o pulses on the last enabled cycle of a loaded interval.
module learn_note_timer #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expire_o = en_i && (count_q == W'(1));

endmodule

// File: rtl/learning_engine.sv
// Learning-mode core: plays each song note, waits for the matching key press and scores it.
// Optional streak counter and every-4th-hit bonus are enabled by defining LEARN_STREAK_EN.
module learning_engine
    import learn_pkg::*;
#(
    parameter int KEY_W    = 4,
    parameter int ADDR_W   = 5,
    parameter int DUR_W    = 26,
    parameter int SCORE_W  = 7,
    parameter int MAX_MISS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEY_W-1:0]   note_value,
    input  logic [DUR_W-1:0]   duration_value,
    input  logic [KEY_W-1:0]   user_input,
    output logic [ADDR_W-1:0]  nxt_learning_memory_location,
    output logic [KEY_W-1:0]   key,
    output logic               key_on,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         streak,
    output logic               hit,
    output logic               miss,
    output logic               done
);

    localparam int TW = DUR_W + 1;
    localparam int MW = $clog2(MAX_MISS + 1);
    localparam logic [KEY_W-1:0] NOTE_REST = KEY_W'(rest_code(KEY_W));
    localparam logic [KEY_W-1:0] NOTE_END  = KEY_W'(end_code(KEY_W));

    learn_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [KEY_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_on_q, key_on_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         streak_q, streak_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               done_q, done_d;
    logic [MW-1:0]      miss_cnt_q, miss_cnt_d;
    logic [KEY_W-1:0]   prev_in_q;

    logic               t_load, t_en, t_expire;
    logic [TW-1:0]      t_val;
    logic [DUR_W-1:0]   dur_eff;
    logic               press, advance, miss_evt;
    logic [1:0]         score_inc;
    logic [SCORE_W:0]   score_sum;

    learn_note_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (t_load),
        .load_val_i (t_val),
        .en_i       (t_en),
        .expire_o   (t_expire)
    );

    // A press is the rising edge of "any key down"; a key already held never counts.
    assign press   = (prev_in_q == '0) && (user_input != '0);
    assign dur_eff = (duration_value == '0) ? DUR_W'(1) : duration_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            key_q      <= '0;
            key_on_q   <= 1'b0;
            score_q    <= '0;
            streak_q   <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            done_q     <= 1'b0;
            miss_cnt_q <= '0;
            prev_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            key_q      <= key_d;
            key_on_q   <= key_on_d;
            score_q    <= score_d;
            streak_q   <= streak_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            done_q     <= done_d;
            miss_cnt_q <= miss_cnt_d;
            prev_in_q  <= user_input;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        note_d     = note_q;
        dur_d      = dur_q;
        key_d      = '0;
        key_on_d   = 1'b0;
        score_d    = score_q;
        streak_d   = streak_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        done_d     = done_q;
        miss_cnt_d = miss_cnt_q;
        t_load     = 1'b0;
        t_val      = '0;
        t_en       = 1'b0;
        advance    = 1'b0;
        miss_evt   = 1'b0;
        score_inc  = 2'd0;
        score_sum  = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    addr_d     = '0;
                    score_d    = '0;
                    streak_d   = '0;
                    miss_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                note_d = note_value;
                dur_d  = dur_eff;
                if (note_value == NOTE_END) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_PROMPT;
                    key_d    = note_value;
                    key_on_d = (note_value != NOTE_REST);
                    t_load   = 1'b1;
                    t_val    = {1'b0, dur_eff};
                end
            end
            ST_PROMPT: begin
                t_en     = 1'b1;
                key_d    = note_q;
                key_on_d = (note_q != NOTE_REST);
                if (t_expire) begin
                    key_d    = '0;
                    key_on_d = 1'b0;
                    if (note_q == NOTE_REST) begin
                        advance = 1'b1;
                    end else begin
                        state_d = ST_LISTEN;
                        t_load  = 1'b1;
                        t_val   = {dur_q, 1'b0};
                    end
                end
            end
            ST_LISTEN: begin
                t_en = 1'b1;
                if (press) begin
                    if (user_input == note_q) begin
                        hit_d     = 1'b1;
                        score_inc = 2'd1;
                        state_d   = ST_RELEASE;
`ifdef LEARN_STREAK_EN
                        if (miss_cnt_q == '0 && streak_q != 4'd15) begin
                            streak_d = streak_q + 4'd1;
                            if ((streak_d % 4'(BONUS_INTERVAL)) == 4'd0) begin
                                score_inc = 2'd2;
                            end
                        end
`endif
                    end else begin
                        miss_evt = 1'b1;
                    end
                end else if (t_expire) begin
                    miss_evt = 1'b1;
                end
                if (miss_evt) begin
                    miss_d   = 1'b1;
                    streak_d = '0;
                    if (miss_cnt_q == MW'(MAX_MISS - 1)) begin
                        advance = 1'b1;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MW'(1);
                        state_d    = ST_PROMPT;
                        key_d      = note_q;
                        key_on_d   = 1'b1;
                        t_load     = 1'b1;
                        t_val      = {1'b0, dur_q};
                    end
                end
            end
            ST_RELEASE: begin
                if (user_input == '0) begin
                    advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The last address ends the song rather than wrapping back to the start.
        if (advance) begin
            miss_cnt_d = '0;
            if (addr_q == '1) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_FETCH;
            end
        end

        if (score_inc != 2'd0) begin
            score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, score_inc};
            score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
    end

    assign nxt_learning_memory_location = addr_q;
    assign key    = key_q;
    assign key_on = key_on_q;
    assign score  = score_q;
    assign streak = streak_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign done   = done_q;

endmodule

// File: tb/tb_learning_engine.sv
// Directed bench for learning_engine: songs from a small synchronous memory model,
// scripted key presses, hand-computed expectations checked with immediate assertions.
module tb_learning_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  note_value;
    logic [25:0] duration_value;
    logic [3:0]  user_input;
    logic [4:0]  addr;
    logic [3:0]  key;
    logic        key_on;
    logic [6:0]  score;
    logic [3:0]  streak;
    logic        hit;
    logic        miss;
    logic        done;

    logic [3:0]  mem_note [32];
    logic [25:0] mem_dur  [32];

    int n_total = 0;
    int n_pass  = 0;

`ifdef LEARN_STREAK_EN
    localparam int EXP_STREAK_SCORE = 10;
    localparam int EXP_STREAK       = 8;
`else
    localparam int EXP_STREAK_SCORE = 8;
    localparam int EXP_STREAK       = 0;
`endif

    learning_engine dut (
        .clk                          (clk),
        .rst                          (rst),
        .start                        (start),
        .note_value                   (note_value),
        .duration_value               (duration_value),
        .user_input                   (user_input),
        .nxt_learning_memory_location (addr),
        .key                          (key),
        .key_on                       (key_on),
        .score                        (score),
        .streak                       (streak),
        .hit                          (hit),
        .miss                         (miss),
        .done                         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        note_value     <= mem_note[addr];
        duration_value <= mem_dur[addr];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_song();
        for (int i = 0; i < 32; i++) begin
            mem_note[i] = 4'hF;
            mem_dur[i]  = 26'd1;
        end
    endtask

    task automatic start_song();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for key_on, then measures how long it stays high; returns in the first LISTEN cycle.
    task automatic run_prompt(input string tag, input int exp_wait, input int exp_len, input int exp_key);
        int w;
        int len;
        logic saw_miss;
        w = 0;
        len = 0;
        saw_miss = 1'b0;
        while (key_on !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
            if (miss === 1'b1) saw_miss = 1'b1;
        end
        check({tag, "_wait"}, 32'(w), 32'(exp_wait));
        check({tag, "_key"}, 32'(key), 32'(exp_key));
        while (key_on === 1'b1 && len < 1000) begin
            len++;
            @(negedge clk);
        end
        check({tag, "_len"}, 32'(len), 32'(exp_len));
        check({tag, "_nomiss"}, 32'(saw_miss), 32'd0);
    endtask

    task automatic press(input logic [3:0] k);
        user_input = k;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (done !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int w;
        int seen;
        rst        = 1'b0;
        start      = 1'b0;
        user_input = 4'd0;
        clear_song();
        repeat (2) @(negedge clk);
        check("rst_key_on", 32'(key_on), 32'd0);
        check("rst_key", 32'(key), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_pulses", {29'd0, hit, miss, done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Song {5/10, 3/10, end}
        mem_note[0] = 4'd5; mem_dur[0] = 26'd10;
        mem_note[1] = 4'd3; mem_dur[1] = 26'd10;
        start_song();
        check("s1_fetch_keyon", 32'(key_on), 32'd0);
        run_prompt("s1n0", 2, 10, 5);
        press(4'd5);
        check("s1_hit0", 32'(hit), 32'd1);
        check("s1_score1", 32'(score), 32'd1);
        user_input = 4'd0;
        @(negedge clk);
        check("s1_hit_pulse", 32'(hit), 32'd0);
        run_prompt("s1n1", 2, 10, 3);
        press(4'd3);
        check("s1_hit1", 32'(hit), 32'd1);
        user_input = 4'd0;
        wait_done("s1");
        check("s1_score2", 32'(score), 32'd2);
        check("s1_addr", 32'(addr), 32'd2);

        // Note 7/8: two wrong presses, then correct
        clear_song();
        mem_note[0] = 4'd7; mem_dur[0] = 26'd8;
        start_song();
        run_prompt("s2a", 2, 8, 7);
        press(4'd2);
        check("s2_miss1", 32'(miss), 32'd1);
        check("s2_replay1", 32'(key_on), 32'd1);
        user_input = 4'd0;
        run_prompt("s2b", 0, 8, 7);
        press(4'd2);
        check("s2_miss2", 32'(miss), 32'd1);
        user_input = 4'd0;
        run_prompt("s2c", 0, 8, 7);
        press(4'd7);
        check("s2_hit", 32'(hit), 32'd1);
        check("s2_nomiss", 32'(miss), 32'd0);
        check("s2_score", 32'(score), 32'd1);
        user_input = 4'd0;
        wait_done("s2");
        check("s2_addr", 32'(addr), 32'd1);

        // Note 4/6: three timeouts force auto-advance
        clear_song();
        mem_note[0] = 4'd4; mem_dur[0] = 26'd6;
        start_song();
        run_prompt("s3a", 2, 6, 4);
        for (int r = 0; r < 3; r++) begin
            w = 0;
            while (miss !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("s3_timeout%0d", r), 32'(w), 32'd12);
            if (r < 2) run_prompt($sformatf("s3r%0d", r), 0, 6, 4);
        end
        check("s3_no_replay", 32'(key_on), 32'd0);
        wait_done("s3");
        check("s3_score", 32'(score), 32'd0);
        check("s3_addr", 32'(addr), 32'd1);

        // Key held through PROMPT is not a press; held key after hit stalls in RELEASE
        start_song();
        w = 0;
        while (key_on !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("s4_wait", 32'(w), 32'd2);
        user_input = 4'd4;
        w = 0;
        while (key_on === 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("s4_len", 32'(w), 32'd6);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (hit === 1'b1) seen++;
        end
        check("s4_held_nohit", 32'(seen), 32'd0);
        user_input = 4'd0;
        @(negedge clk);
        press(4'd4);
        check("s4_hit", 32'(hit), 32'd1);
        check("s4_score", 32'(score), 32'd1);
        repeat (10) @(negedge clk);
        check("s4_hold_done", 32'(done), 32'd0);
        check("s4_hold_addr", 32'(addr), 32'd0);
        user_input = 4'd0;
        wait_done("s4");
        check("s4_addr", 32'(addr), 32'd1);

        // Rest between notes: {2/4, 0/5, 6/4, end}
        clear_song();
        mem_note[0] = 4'd2; mem_dur[0] = 26'd4;
        mem_note[1] = 4'd0; mem_dur[1] = 26'd5;
        mem_note[2] = 4'd6; mem_dur[2] = 26'd4;
        start_song();
        run_prompt("s5n0", 2, 4, 2);
        press(4'd2);
        check("s5_hit0", 32'(hit), 32'd1);
        user_input = 4'd0;
        run_prompt("s5n2", 10, 4, 6);
        check("s5_addr_n2", 32'(addr), 32'd2);
        press(4'd6);
        check("s5_hit2", 32'(hit), 32'd1);
        check("s5_score", 32'(score), 32'd2);
        user_input = 4'd0;
        wait_done("s5");
        check("s5_addr", 32'(addr), 32'd3);

        // Eight first-try hits, duration 2 each
        clear_song();
        for (int i = 0; i < 8; i++) begin
            mem_note[i] = 4'(i + 1);
            mem_dur[i]  = 26'd2;
        end
        start_song();
        for (int i = 0; i < 8; i++) begin
            run_prompt($sformatf("s6n%0d", i), (i == 0) ? 2 : 3, 2, i + 1);
            press(4'(i + 1));
            check($sformatf("s6_hit%0d", i), 32'(hit), 32'd1);
            user_input = 4'd0;
        end
        wait_done("s6");
        check("s6_score", 32'(score), 32'(EXP_STREAK_SCORE));
        check("s6_streak", 32'(streak), 32'(EXP_STREAK));

        // Reset in the middle of the second note's PROMPT
        start_song();
        run_prompt("s7n0", 2, 2, 1);
        press(4'd1);
        check("s7_score_pre", 32'(score), 32'd1);
        user_input = 4'd0;
        w = 0;
        while (key_on !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("s7_prompt2", 32'(key), 32'd2);
        rst = 1'b0;
        #1;
        check("s7_rst_key_on", 32'(key_on), 32'd0);
        check("s7_rst_key", 32'(key), 32'd0);
        check("s7_rst_score", 32'(score), 32'd0);
        check("s7_rst_streak", 32'(streak), 32'd0);
        check("s7_rst_addr", 32'(addr), 32'd0);
        check("s7_rst_pulses", {29'd0, hit, miss, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_song();
        run_prompt("s7post", 2, 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
